data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 3, meaning log2 of the number of direct-mapped 4-byte blocks; tag width = 6 - INDEX_BITS.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on posedge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port read, input, 1, CPU read request.
REQ-005 The block SHALL have port write, input, 1, CPU write request.
REQ-006 The block SHALL have port address, input, 8, CPU byte address: [7:2+INDEX_BITS] tag, [1+INDEX_BITS:2] index, [1:0] byte offset.
REQ-007 The block SHALL have port writedata, input, 8, CPU store byte.
REQ-008 The block SHALL have port readdata, output, 8, CPU load byte.
REQ-009 The block SHALL have port busywait, output, 1, CPU stall while high.
REQ-010 The block SHALL have ports mem_read, output, 1, and mem_write, output, 1, the block-memory requests, never both high.
REQ-011 The block SHALL have port mem_address, output, 6, the 4-byte block address.
REQ-012 The block SHALL have port mem_writedata, output, 32, the write-back block, byte 0 in [7:0].
REQ-013 The block SHALL have ports mem_readdata, input, 32, the fill block, and mem_busywait, input, 1, high while the memory is busy.

Function
REQ-014 The block SHALL be a direct-mapped, write-back, write-allocate cache; per block: 32-bit data, tag, valid bit, dirty bit.
REQ-015 The block SHALL define hit = valid[index] && tag[index] == address tag, evaluated combinationally.
REQ-016 The block SHALL implement the FSM states IDLE, WRITE_BACK, FETCH and UPDATE.
REQ-017 IDLE: busywait = (read ^ write) && !hit; mem_read = mem_write = 0.
REQ-018 IDLE with read=1, write=0 and a hit SHALL drive readdata combinationally with the offset byte, zero-cycle latency, and SHALL keep busywait 0.
REQ-019 IDLE with write=1, read=0 and a hit SHALL write the offset byte at the next posedge, set dirty=1 and keep busywait 0.
REQ-020 An IDLE miss SHALL go at the next posedge to WRITE_BACK when valid && dirty, otherwise to FETCH.
REQ-021 WRITE_BACK SHALL drive mem_write=1, mem_address={stored tag, index} and mem_writedata=stored block; it SHALL move to FETCH at the first posedge where mem_busywait==0, excluding the entry posedge.
REQ-022 FETCH SHALL drive mem_read=1 and mem_address={request tag, index}; it SHALL move to UPDATE at the first posedge where mem_busywait==0, excluding the entry posedge.
REQ-023 UPDATE SHALL write mem_readdata, the request tag, valid=1 and dirty=0 at its posedge, then go to IDLE, where the request completes as a hit per REQ-018/019.
REQ-024 busywait SHALL be 1 in all states other than IDLE.
REQ-025 read=write=1 SHALL be ignored: no state change and busywait=0.
REQ-026 readdata SHALL be 0 when no read hit is in progress.

Reset
REQ-027 With reset=1 at a posedge, the block SHALL clear all valid and dirty bits and set state=IDLE, which forces mem_read=0, mem_write=0 and busywait=0 from the next cycle; data and tag arrays are not cleared.
REQ-028 A reset during WRITE_BACK or FETCH SHALL abandon the transfer; no fill and no dirty update SHALL occur.

Configuration
REQ-029 When DATA_CACHE_STATS_EN is defined, the block SHALL add outputs hit_count[15:0] and miss_count[15:0]; each counts IDLE hits or misses once per request, saturates at 16'hFFFF and clears on reset. A request that misses and then hits after the fill SHALL count as one miss only. When undefined, these ports and counters SHALL be absent.

Verification
REQ-030 The bench SHALL cover: after reset, read 0x05 -> FETCH of block 0x01 with mem_read=1; after mem_busywait falls, UPDATE then readdata = mem_readdata[15:8], busywait 0.
REQ-031 The bench SHALL cover: write 0xAB to 0x05 after the fill -> busywait stays 0, dirty[1]=1; read 0x05 -> 0xAB in the same cycle.
REQ-032 The bench SHALL cover: with INDEX_BITS=3, read 0x25 (same index, tag 1) while block 1 is dirty -> WRITE_BACK with mem_address=0x01 and mem_writedata[15:8]=0xAB, then FETCH with mem_address=0x09.
REQ-033 The bench SHALL cover: reset asserted mid-FETCH -> next cycle mem_read=0 and busywait=0; read 0x05 misses again.
REQ-034 The bench SHALL cover: read=write=1 -> busywait=0 and mem_read=mem_write=0 for the whole cycle.
REQ-035 The bench SHALL cover, with DATA_CACHE_STATS_EN: sequence miss, hit, hit -> miss_count=1 and hit_count=2.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// 2^INDEX_BITS blocks of 4 bytes each, an 8-bit CPU port and a 32-bit block memory port.
// Optional build macro DATA_CACHE_STATS_EN adds saturating hit/miss counters.
module data_cache #(
   parameter int unsigned INDEX_BITS = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [7:0]  address,
   input  logic [7:0]  writedata,
   output logic [7:0]  readdata,
   output logic        busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [5:0]  mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait
`ifdef DATA_CACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int unsigned TAG_BITS   = 6 - INDEX_BITS;
   localparam int unsigned NUM_BLOCKS = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_BACK,
      FETCH,
      UPDATE
   } state_t;

   state_t state;

   logic [31:0]           data_array [NUM_BLOCKS];
   logic [TAG_BITS-1:0]   tag_array  [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] valid_bits;
   logic [NUM_BLOCKS-1:0] dirty_bits;

   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_index;
   logic [1:0]            req_offset;
   logic                  cpu_req;
   logic                  hit;
   logic [31:0]           cur_block;

   assign req_tag    = address[7 -: TAG_BITS];
   assign req_index  = address[2 +: INDEX_BITS];
   assign req_offset = address[1:0];
   assign cpu_req    = read ^ write;
   assign cur_block  = data_array[req_index];
   assign hit        = valid_bits[req_index] && (tag_array[req_index] == req_tag);

   // Control FSM: state, valid/dirty bookkeeping and registered memory request strobes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         valid_bits <= '0;
         dirty_bits <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req && hit) begin
                  if (write) dirty_bits[req_index] <= 1'b1;
               end else if (cpu_req) begin
                  if (valid_bits[req_index] && dirty_bits[req_index]) begin
                     state     <= WRITE_BACK;
                     mem_write <= 1'b1;
                  end else begin
                     state    <= FETCH;
                     mem_read <= 1'b1;
                  end
               end
            end
            WRITE_BACK: begin
               if (!mem_busywait) begin
                  state     <= FETCH;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
               end
            end
            FETCH: begin
               if (!mem_busywait) begin
                  state    <= UPDATE;
                  mem_read <= 1'b0;
               end
            end
            UPDATE: begin
               state                 <= IDLE;
               valid_bits[req_index] <= 1'b1;
               dirty_bits[req_index] <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

   // Data and tag storage: byte writes on write hits, whole-block fills in UPDATE; never reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == IDLE && write && !read && hit) begin
            data_array[req_index][{req_offset, 3'b000} +: 8] <= writedata;
         end else if (state == UPDATE) begin
            data_array[req_index] <= mem_readdata;
            tag_array[req_index]  <= req_tag;
         end
      end
   end

   // CPU-side and memory-side combinational outputs.
   always_comb begin
      readdata      = '0;
      busywait      = 1'b1;
      mem_address   = {req_tag, req_index};
      mem_writedata = cur_block;
      if (state == IDLE) begin
         busywait = cpu_req && !hit;
         if (read && !write && hit) readdata = cur_block[{req_offset, 3'b000} +: 8];
      end
      if (state == WRITE_BACK) mem_address = {tag_array[req_index], req_index};
   end

`ifdef DATA_CACHE_STATS_EN
   // A request completing after its fill was already counted as a miss; this flag suppresses its hit.
   logic fill_done;

   // Saturating hit/miss counters sampled on IDLE request cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
         fill_done  <= 1'b0;
      end else begin
         if (state == UPDATE) fill_done <= 1'b1;
         if (state == IDLE) begin
            fill_done <= 1'b0;
            if (cpu_req && hit && !fill_done && hit_count != '1)
               hit_count <= hit_count + 16'd1;
            if (cpu_req && !hit && miss_count != '1)
               miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed scoreboard bench for data_cache (INDEX_BITS=3).
module tb_data_cache;

   logic        clock = 1'b0;
   logic        reset;
   logic        read;
   logic        write;
   logic [7:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;
`ifdef DATA_CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned fails  = 0;

   string       q_name [$];
   logic [31:0] q_val  [$];

   data_cache #(.INDEX_BITS(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .read         (read),
      .write        (write),
      .address      (address),
      .writedata    (writedata),
      .readdata     (readdata),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_writedata(mem_writedata),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
`ifdef DATA_CACHE_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_val(input string name, input logic [31:0] val);
      q_name.push_back(name);
      q_val.push_back(val);
   endtask

   // Pops every pending expectation and compares it with the named DUT output.
   task automatic settle();
      string       n;
      logic [31:0] e;
      logic [31:0] o;
      #1;
      while (q_name.size() > 0) begin
         n = q_name.pop_front();
         e = q_val.pop_front();
         case (n)
            "busywait":      o = {31'b0, busywait};
            "mem_read":      o = {31'b0, mem_read};
            "mem_write":     o = {31'b0, mem_write};
            "mem_address":   o = {26'b0, mem_address};
            "mem_writedata": o = mem_writedata;
            "readdata":      o = {24'b0, readdata};
`ifdef DATA_CACHE_STATS_EN
            "hit_count":     o = {16'b0, hit_count};
            "miss_count":    o = {16'b0, miss_count};
`endif
            default:         o = 'x;
         endcase
         checks++;
         assert (o === e) passes++;
         else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", n, o, e);
         end
      end
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      mem_busywait = 1'b1; mem_readdata = '0;
      tick(); tick();
      reset = 1'b0;
      expect_val("busywait", 0); expect_val("mem_read", 0);
      expect_val("mem_write", 0); expect_val("readdata", 0);
      settle();

      // Cold read miss on 0x05 -> FETCH of block 0x01.
      read = 1'b1; address = 8'h05;
      expect_val("busywait", 1); expect_val("mem_read", 0); expect_val("readdata", 0);
      settle();
      tick();
      expect_val("mem_read", 1); expect_val("mem_write", 0);
      expect_val("mem_address", 32'h01); expect_val("busywait", 1);
      settle();
      tick();
      expect_val("mem_read", 1);
      settle();
      mem_busywait = 1'b0; mem_readdata = 32'h4433_2211;
      tick();
      mem_busywait = 1'b1;
      expect_val("mem_read", 0); expect_val("busywait", 1);
      settle();
      tick();
      expect_val("readdata", 32'h22); expect_val("busywait", 0);
      settle();

      // Write hit then same-cycle read-back.
      read = 1'b0; write = 1'b1; writedata = 8'hAB;
      expect_val("busywait", 0); expect_val("readdata", 0);
      settle();
      tick();
      read = 1'b1; write = 1'b0;
      expect_val("readdata", 32'hAB); expect_val("busywait", 0);
      settle();

      // Conflict miss on dirty block -> write-back of 0x01 then fetch of 0x09.
      address = 8'h25;
      expect_val("busywait", 1); expect_val("readdata", 0);
      settle();
      tick();
      expect_val("mem_write", 1); expect_val("mem_read", 0);
      expect_val("mem_address", 32'h01); expect_val("mem_writedata", 32'h4433_AB11);
      expect_val("busywait", 1);
      settle();
      tick();
      expect_val("mem_write", 1);
      settle();
      mem_busywait = 1'b0;
      tick();
      mem_busywait = 1'b1;
      expect_val("mem_read", 1); expect_val("mem_write", 0); expect_val("mem_address", 32'h09);
      settle();

      // Reset mid-FETCH abandons the transfer.
      reset = 1'b1;
      tick();
      reset = 1'b0; read = 1'b0;
      expect_val("mem_read", 0); expect_val("mem_write", 0); expect_val("busywait", 0);
      settle();
      read = 1'b1; address = 8'h05;
      expect_val("busywait", 1);
      settle();
      tick();
      expect_val("mem_read", 1); expect_val("mem_write", 0); expect_val("mem_address", 32'h01);
      settle();
      mem_busywait = 1'b0; mem_readdata = 32'hDDCC_BBAA;
      tick();
      mem_busywait = 1'b1;
      tick();
      expect_val("readdata", 32'hBB); expect_val("busywait", 0);
      settle();
      address = 8'h07;
      expect_val("readdata", 32'hDD);
      settle();
      address = 8'h04;
      expect_val("readdata", 32'hAA);
      settle();
      read = 1'b0;
      expect_val("readdata", 0);
      settle();

      // read=write=1 is ignored, even on a missing address.
      read = 1'b1; write = 1'b1; address = 8'h25;
      expect_val("busywait", 0); expect_val("mem_read", 0);
      expect_val("mem_write", 0); expect_val("readdata", 0);
      settle();
      #3;
      expect_val("busywait", 0); expect_val("mem_read", 0); expect_val("mem_write", 0);
      settle();
      tick();
      expect_val("busywait", 0); expect_val("mem_read", 0); expect_val("mem_write", 0);
      settle();

      // Miss, hit, hit sequence on block 3.
      read = 1'b0; write = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
`ifdef DATA_CACHE_STATS_EN
      expect_val("hit_count", 0); expect_val("miss_count", 0);
`endif
      read = 1'b1; address = 8'h0D;
      expect_val("busywait", 1);
      settle();
      tick();
      expect_val("mem_read", 1); expect_val("mem_address", 32'h03);
      settle();
      mem_busywait = 1'b0; mem_readdata = 32'h8967_4523;
      tick();
      mem_busywait = 1'b1;
      tick();
      expect_val("readdata", 32'h45); expect_val("busywait", 0);
      settle();
      tick();
      address = 8'h0E;
      expect_val("readdata", 32'h67);
      settle();
      tick();
      address = 8'h0F;
      expect_val("readdata", 32'h89);
      settle();
      tick();
      read = 1'b0;
`ifdef DATA_CACHE_STATS_EN
      expect_val("miss_count", 1); expect_val("hit_count", 2);
`endif
      expect_val("readdata", 0);
      settle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
